// File: rtl/gray_ptr_sync.sv
// Destination-side Gray pointer crossing for an async FIFO: synchronise, convert to
// binary, report advance, fill distance, empty/full flag and sticky error flags.
module gray_ptr_sync #(
    parameter int LENGTH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LENGTH-1:0] gray_in,
    input  logic [LENGTH-1:0] local_ptr,
    input  logic              err_clr,
    output logic [LENGTH-1:0] remote_bin,
    output logic              adv,
    output logic [LENGTH-1:0] adv_cnt,
    output logic [LENGTH-1:0] diff,
    output logic              flag,
    output logic              gray_err,
    output logic              ptr_err
);

    if (LENGTH < 2 || LENGTH > 16) begin : g_bad_length
        $error("gray_ptr_sync: LENGTH must be in 2..16");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
    end
    if (MODE < 0 || MODE > 1) begin : g_bad_mode
        $error("gray_ptr_sync: MODE must be 0 or 1");
    end

    localparam logic [LENGTH-1:0] HALF = {1'b1, {(LENGTH-1){1'b0}}};

    logic [LENGTH-1:0] sync_q [SYNC_STAGES];
    logic [LENGTH-1:0] s_gray;
    logic [LENGTH-1:0] s_prev_q;
    logic [LENGTH-1:0] remote_bin_q, remote_bin_d;
    logic              adv_q, adv_d;
    logic [LENGTH-1:0] adv_cnt_q, adv_cnt_d;
    logic              gray_err_q, gray_err_d;
    logic              ptr_err_q, ptr_err_d;
    logic [LENGTH-1:0] step;
    logic              gray_set;
    logic              ptr_set;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        remote_bin_d = '0;
        remote_bin_d[LENGTH-1] = s_gray[LENGTH-1];
        for (int k = LENGTH - 2; k >= 0; k--) begin
            remote_bin_d[k] = remote_bin_d[k+1] ^ s_gray[k];
        end
    end

    if (MODE == 0) begin : g_read_side
        assign diff = remote_bin_q - local_ptr;
        assign flag = (diff == '0);
    end else begin : g_write_side
        assign diff = local_ptr - remote_bin_q;
        assign flag = (diff == HALF);
    end

    // More than one bit set in the step means an illegal Gray transition.
    assign step     = s_gray ^ s_prev_q;
    assign gray_set = (step & (step - LENGTH'(1))) != '0;
    assign ptr_set  = diff > HALF;

    always_comb begin
        adv_d      = (remote_bin_d != remote_bin_q);
        adv_cnt_d  = adv_d ? (remote_bin_d - remote_bin_q) : '0;
        gray_err_d = gray_set | (gray_err_q & ~err_clr);
        ptr_err_d  = ptr_set  | (ptr_err_q  & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q     <= '0;
            remote_bin_q <= '0;
            adv_q        <= 1'b0;
            adv_cnt_q    <= '0;
            gray_err_q   <= 1'b0;
            ptr_err_q    <= 1'b0;
        end else begin
            s_prev_q     <= s_gray;
            remote_bin_q <= remote_bin_d;
            adv_q        <= adv_d;
            adv_cnt_q    <= adv_cnt_d;
            gray_err_q   <= gray_err_d;
            ptr_err_q    <= ptr_err_d;
        end
    end

    assign remote_bin = remote_bin_q;
    assign adv        = adv_q;
    assign adv_cnt    = adv_cnt_q;
    assign gray_err   = gray_err_q;
    assign ptr_err    = ptr_err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: one read-side and one write-side instance,
// LENGTH=4, two sync stages, hand-computed expectations.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] g0, l0, g1, l1;
    logic       c0, c1;
    logic [3:0] rb0, ac0, df0, rb1, ac1, df1;
    logic       adv0, fl0, ge0, pe0, adv1, fl1, ge1, pe1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.LENGTH(4), .SYNC_STAGES(2), .MODE(0)) u_rd (
        .clk(clk), .rst_n(rst_n), .gray_in(g0), .local_ptr(l0), .err_clr(c0),
        .remote_bin(rb0), .adv(adv0), .adv_cnt(ac0), .diff(df0), .flag(fl0),
        .gray_err(ge0), .ptr_err(pe0)
    );

    gray_ptr_sync #(.LENGTH(4), .SYNC_STAGES(2), .MODE(1)) u_wr (
        .clk(clk), .rst_n(rst_n), .gray_in(g1), .local_ptr(l1), .err_clr(c1),
        .remote_bin(rb1), .adv(adv1), .adv_cnt(ac1), .diff(df1), .flag(fl1),
        .gray_err(ge1), .ptr_err(pe1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        g0 = 4'b0110; l0 = 4'd0; c0 = 1'b0;
        g1 = 4'd0;    l1 = 4'd0; c1 = 1'b0;
        #12;
        chk("rst_remote_bin", rb0, 0);
        chk("rst_adv", adv0, 0);
        chk("rst_adv_cnt", ac0, 0);
        chk("rst_gray_err", ge0, 0);
        chk("rst_ptr_err", pe0, 0);
        chk("rst_diff", df0, 0);
        chk("rst_empty", fl0, 1);
        chk("rst_wr_diff", df1, 0);
        chk("rst_wr_full", fl1, 0);

        g0 = 4'b0000;
        @(negedge clk) rst_n = 1'b1;
        tick(3);

        g0 = 4'b0001;
        tick(2);
        chk("lat_remote_e2", rb0, 0);
        chk("lat_adv_e2", adv0, 0);
        tick(1);
        chk("lat_remote_e3", rb0, 1);
        chk("lat_adv_e3", adv0, 1);
        chk("lat_adv_cnt_e3", ac0, 1);
        chk("lat_diff", df0, 1);
        chk("lat_empty", fl0, 0);
        tick(1);
        chk("lat_adv_e4", adv0, 0);
        chk("lat_adv_cnt_e4", ac0, 0);
        chk("lat_remote_e4", rb0, 1);

        g0 = 4'b0000;
        tick(4);
        chk("back_remote", rb0, 0);
        chk("back_empty", fl0, 1);

        g0 = 4'b0011;
        tick(2);
        chk("gjump_err_e2", ge0, 0);
        tick(1);
        chk("gjump_remote", rb0, 2);
        chk("gjump_adv_cnt", ac0, 2);
        chk("gjump_err_e3", ge0, 1);

        g0 = 4'b0101;
        tick(2);
        c0 = 1'b1;
        tick(1);
        c0 = 1'b0;
        chk("gjump2_set_wins", ge0, 1);
        chk("gjump2_remote", rb0, 6);
        chk("gjump2_adv_cnt", ac0, 4);
        c0 = 1'b1;
        tick(1);
        c0 = 1'b0;
        chk("gerr_cleared", ge0, 0);

        g0 = 4'b0111;
        tick(3);
        chk("pre_rst_remote", rb0, 5);
        chk("pre_rst_adv", adv0, 1);
        chk("pre_rst_adv_cnt", ac0, 4'hF);

        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_remote", rb0, 0);
        chk("midrst_adv", adv0, 0);
        chk("midrst_adv_cnt", ac0, 0);
        chk("midrst_diff", df0, 0);
        chk("midrst_empty", fl0, 1);

        g0 = 4'b1000;
        l0 = 4'd0;
        @(negedge clk) rst_n = 1'b1;
        tick(2);
        chk("reload_remote_e2", rb0, 0);
        tick(1);
        chk("reload_remote_e3", rb0, 15);
        chk("reload_gray_err", ge0, 0);
        l0 = 4'b0111;
        #1;
        chk("wrap_diff", df0, 8);
        chk("wrap_empty", fl0, 0);
        tick(1);
        chk("wrap_ptr_err", pe0, 0);
        l0 = 4'b1111;
        #1;
        chk("wrap_diff_zero", df0, 0);
        chk("wrap_empty_now", fl0, 1);

        l1 = 4'b1000;
        #1;
        chk("wr_diff8", df1, 8);
        chk("wr_full", fl1, 1);
        tick(1);
        chk("wr_ptr_err_ok", pe1, 0);
        l1 = 4'b1001;
        #1;
        chk("wr_diff9", df1, 9);
        chk("wr_full_off", fl1, 0);
        tick(1);
        chk("wr_ptr_err_set", pe1, 1);
        l1 = 4'b1000;
        tick(1);
        chk("wr_ptr_err_sticky", pe1, 1);
        c1 = 1'b1;
        tick(1);
        c1 = 1'b0;
        chk("wr_ptr_err_clr", pe1, 0);
        l1 = 4'b1001;
        c1 = 1'b1;
        tick(1);
        c1 = 1'b0;
        chk("wr_ptr_set_wins", pe1, 1);
        l1 = 4'b1000;
        c1 = 1'b1;
        tick(1);
        c1 = 1'b0;
        chk("wr_ptr_err_clr2", pe1, 0);
        chk("wr_gray_err", ge1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
